// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types, default timing and init ROM for the HD44780
//                character LCD sequencer (lcd_ctrl / lcd_cmd_fifo).
//                The init ROM is only referenced when LCD_INIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  // FSM states of the bus sequencer; PWRUP is only reachable with LCD_INIT_EN.
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WAIT  = 3'd5
  } lcd_state_e;

  // One queued LCD bus command: RS (1 = data, 0 = instruction) and DB[7:0].
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Default timing in clock cycles at 50 MHz.
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_T_SETUP_CYC = 2;
  localparam int DEF_T_EN_CYC    = 12;
  localparam int DEF_T_HOLD_CYC  = 2;
  localparam int DEF_T_EXEC_CYC  = 2000;    // 40 us
  localparam int DEF_T_LONG_CYC  = 82000;   // 1.64 ms
  localparam int DEF_T_PWRUP_CYC = 750000;  // 15 ms

  // Power-on init: 8-bit/2-line/5x8 (x3), display on, clear, entry mode.
  localparam int         INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input lcd_cmd_t cmd);
    return !cmd.rs && ((cmd.data == 8'h01) || (cmd.data == 8'h02) || (cmd.data == 8'h03));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
// ============================================================================
//  Module      : lcd_cmd_fifo
//  Description : Synchronous first-word-fall-through FIFO of lcd_cmd_t.
//                o_head shows the oldest entry whenever o_empty = 0.
//                Pushes when full and pops when empty are ignored.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_push/i_push_data,
//                i_pop, o_head, o_count, o_full, o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8  // power of two, >= 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  lcd_cmd_t               i_push_data,
  input  logic                   i_pop,
  output lcd_cmd_t               o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(DEPTH);

  lcd_cmd_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == C_DEPTH);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl.sv
// ============================================================================
//  Module      : lcd_ctrl
//  Description : HD44780 character LCD bus sequencer. Commands pushed by the
//                LSU are queued in lcd_cmd_fifo and replayed with setup, EN
//                pulse, hold and execution-delay timing.
//                Optional macro LCD_INIT_EN: after reset wait T_PWRUP_CYC and
//                issue the built-in init ROM before serving the FIFO.
//  Ports       : i_clk, i_rst_n (sync, active-low)
//                i_cmd_vld, i_cmd_data[8:0] = {RS, DB}  - command push
//                o_lcd_data/o_lcd_rs/o_lcd_rw/o_lcd_en  - LCD bus
//                o_lcd_on  - panel power enable
//                o_busy, o_fifo_cnt, o_ovf (drop pulse)  - status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int T_SETUP_CYC = DEF_T_SETUP_CYC,
  parameter int T_EN_CYC    = DEF_T_EN_CYC,
  parameter int T_HOLD_CYC  = DEF_T_HOLD_CYC,
  parameter int T_EXEC_CYC  = DEF_T_EXEC_CYC,
  parameter int T_LONG_CYC  = DEF_T_LONG_CYC,
  parameter int T_PWRUP_CYC = DEF_T_PWRUP_CYC
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_cmd_vld,
  input  logic [31:0]                 i_cmd_data,
  output logic [7:0]                  o_lcd_data,
  output logic                        o_lcd_rs,
  output logic                        o_lcd_rw,
  output logic                        o_lcd_en,
  output logic                        o_lcd_on,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic                        o_ovf
);

  // One shared down-counter; sized for the longest wait it ever holds.
  localparam int C_CNT_MAX = (T_LONG_CYC > T_PWRUP_CYC) ? T_LONG_CYC : T_PWRUP_CYC;
  localparam int CW        = $clog2(C_CNT_MAX + 1);

  lcd_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_en;
  logic          r_lcd_on;
  logic          r_ovf;

  lcd_cmd_t      w_push_cmd;
  lcd_cmd_t      w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_init_pending;
  logic          w_unused_bits;

`ifdef LCD_INIT_EN
  localparam int              IW           = $clog2(INIT_LEN + 1);
  localparam logic [IW-1:0]   C_INIT_END   = IW'(INIT_LEN);
  localparam lcd_state_e      C_RST_STATE  = ST_PWRUP;
  localparam logic [CW-1:0]   C_RST_CNT    = CW'(T_PWRUP_CYC - 1);

  logic [IW-1:0] r_init_idx;
  assign w_init_pending = (r_init_idx != C_INIT_END);
`else
  localparam lcd_state_e      C_RST_STATE  = ST_IDLE;
  localparam logic [CW-1:0]   C_RST_CNT    = '0;

  assign w_init_pending = 1'b0;
`endif

  assign w_unused_bits = ^i_cmd_data[31:9];
  assign w_push_cmd    = '{rs: i_cmd_data[8], data: i_cmd_data[7:0]};

  // The FIFO is held off while the init ROM still has entries to send.
  assign w_pop = (r_state == ST_IDLE) && !w_init_pending && !w_empty;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_cmd_vld),
    .i_push_data (w_push_cmd),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (o_fifo_cnt),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A push while full is lost even if a pop happens in the same cycle,
  // because acceptance looks at the registered count only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf    <= 1'b0;
      r_lcd_on <= 1'b0;
    end else begin
      r_ovf    <= i_cmd_vld && w_full;
      r_lcd_on <= 1'b1;
    end
  end

  // Bus sequencer. Each state loads r_cnt with (duration - 1) on entry and
  // leaves when it reaches zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= C_RST_STATE;
      r_cnt   <= C_RST_CNT;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
`ifdef LCD_INIT_EN
      r_init_idx <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
`ifdef LCD_INIT_EN
          if (w_init_pending) begin
            r_data     <= INIT_ROM[r_init_idx];
            r_rs       <= 1'b0;
            r_init_idx <= r_init_idx + 1'b1;
            r_state    <= ST_SETUP;
            r_cnt      <= CW'(T_SETUP_CYC - 1);
          end else
`endif
          if (!w_empty) begin
            r_data  <= w_head.data;
            r_rs    <= w_head.rs;
            r_state <= ST_SETUP;
            r_cnt   <= CW'(T_SETUP_CYC - 1);
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_PULSE;
            r_en    <= 1'b1;
            r_cnt   <= CW'(T_EN_CYC - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_HOLD;
            r_en    <= 1'b0;
            r_cnt   <= CW'(T_HOLD_CYC - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_WAIT;
            r_cnt   <= is_long_cmd('{rs: r_rs, data: r_data}) ? CW'(T_LONG_CYC - 1)
                                                              : CW'(T_EXEC_CYC - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef LCD_INIT_EN
        ST_PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_lcd_on;
  assign o_ovf      = r_ovf;
  assign o_busy     = !w_empty || (r_state != ST_IDLE) || w_init_pending;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
//  Module      : tb_lcd_ctrl
//  Description : Self-checking bench for lcd_ctrl. A timeline model (command
//                age since pop) predicts every output each cycle; directed
//                tests add literal cycle-exact expectations.
//                Honours LCD_INIT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

  localparam int DEPTH = 4;
  localparam int TS    = 2;
  localparam int TE    = 3;
  localparam int TH    = 1;
  localparam int TX    = 5;
  localparam int TL    = 20;
  localparam int TP    = 10;
  localparam int NW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic [31:0]   cmd_data = 32'h0;
  logic [7:0]    lcd_data;
  logic          lcd_rs;
  logic          lcd_rw;
  logic          lcd_en;
  logic          lcd_on;
  logic          busy;
  logic [NW-1:0] fifo_cnt;
  logic          ovf;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .T_SETUP_CYC (TS),
    .T_EN_CYC    (TE),
    .T_HOLD_CYC  (TH),
    .T_EXEC_CYC  (TX),
    .T_LONG_CYC  (TL),
    .T_PWRUP_CYC (TP)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_vld  (cmd_vld),
    .i_cmd_data (cmd_data),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on),
    .o_busy     (busy),
    .o_fifo_cnt (fifo_cnt),
    .o_ovf      (ovf)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // ---------------- timeline model ----------------
  logic [8:0] mq[$];      // user command queue
  logic [8:0] iq[$];      // pending init commands
  int         age = 0;    // cycles since the current command was popped, 0 = idle
  int         len = 0;    // pop-to-idle length of the current command
  int         pwr = 0;    // remaining power-up cycles
  logic [7:0] m_data = 8'h0;
  logic       m_rs = 1'b0;
  logic       m_on = 1'b0;
  logic       m_ovf = 1'b0;
  bit         m_valid = 1'b0;

  function automatic int wait_of(input logic [8:0] c);
    if (!c[8] && (c[7:0] == 8'h01 || c[7:0] == 8'h02 || c[7:0] == 8'h03)) return TL;
    return TX;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      iq.delete();
      age = 0; pwr = 0;
      m_data = 8'h0; m_rs = 1'b0; m_on = 1'b0; m_ovf = 1'b0;
`ifdef LCD_INIT_EN
      pwr = TP;
      iq  = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
`endif
      m_valid = 1'b1;
    end else begin
      int         n0;
      bit         idle;
      logic [8:0] c;
      n0   = mq.size();
      idle = (age == 0) && (pwr == 0);
      m_on = 1'b1;
      if (pwr > 0) pwr--;
      else if (age > 0) begin
        age++;
        if (age == len) age = 0;
      end
      if (idle && (iq.size() > 0 || mq.size() > 0)) begin
        if (iq.size() > 0) c = iq.pop_front();
        else               c = mq.pop_front();
        m_data = c[7:0];
        m_rs   = c[8];
        age    = 1;
        len    = 1 + TS + TE + TH + wait_of(c);
      end
      m_ovf = 1'b0;
      if (cmd_vld) begin
        if (n0 < DEPTH) mq.push_back(cmd_data[8:0]);
        else            m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("lcd_data", int'(lcd_data), int'(m_data));
      check("lcd_rs",   int'(lcd_rs),   int'(m_rs));
      check("lcd_rw",   int'(lcd_rw),   0);
      check("lcd_en",   int'(lcd_en),   int'(age >= 1 + TS && age <= TS + TE));
      check("lcd_on",   int'(lcd_on),   int'(m_on));
      check("busy",     int'(busy),     int'(mq.size() > 0 || iq.size() > 0 || age > 0 || pwr > 0));
      check("fifo_cnt", int'(fifo_cnt), mq.size());
      check("ovf",      int'(ovf),      int'(m_ovf));
    end
  end

  // ---------------- EN pulse / ovf monitor ----------------
  int   rise_c[$];
  int   rise_d[$];
  int   wid[$];
  int   w_cur = 0;
  int   ovf_n = 0;
  logic en_q = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !en_q) begin
      rise_c.push_back(cyc);
      rise_d.push_back(int'({lcd_rs, lcd_data}));
      w_cur = 0;
    end
    if (lcd_en) w_cur++;
    if (!lcd_en && en_q) wid.push_back(w_cur);
    if (ovf) ovf_n++;
    en_q = lcd_en;
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [31:0] d);
    cmd_data = d;
    cmd_vld  = 1'b1;
    @(negedge clk);
    cmd_vld  = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int fall);
    fall = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
    if (fall < 0) begin
      checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", maxc);
    end
  endtask

  // Push one command into an idle controller; check pulse timing and busy fall.
  task automatic single(input logic [31:0] d, input int exp_len);
    int p, b, f;
    p = cyc;
    b = rise_c.size();
    push(d);
    wait_idle(200, f);
    repeat (2) @(negedge clk);
    check("single_fall", f - p, 1 + exp_len);
    check("single_npulse", rise_c.size() - b, 1);
    if (rise_c.size() > b) begin
      check("single_rise", rise_c[b] - p, 1 + 1 + TS);
      check("single_cmd", rise_d[b], int'(d[8:0]));
      check("single_width", wid[b], TE);
    end
  endtask

  initial begin
    int x, b, f, o0;
    logic [8:0] init_exp [7];
    init_exp = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h141};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", int'(lcd_en), 0);
    check("rst_on", int'(lcd_on), 0);
    check("rst_data", int'(lcd_data), 0);
    b = rise_c.size();
    rst_n = 1'b1;
    x = cyc;
`ifdef LCD_INIT_EN
    repeat (2) @(negedge clk);
    push(32'h0000_0141);
    wait_idle(400, f);
    repeat (2) @(negedge clk);
    check("init_npulse", rise_c.size() - b, 7);
    if (rise_c.size() - b >= 7) begin
      check("init_first_rise", rise_c[b] - x, TP + 1 + TS);
      for (int i = 0; i < 7; i++) check("init_cmd", rise_d[b + i], int'(init_exp[i]));
      check("init_gap_clear", rise_c[b + 5] - rise_c[b + 4], 1 + TS + TE + TH + TL);
      check("init_gap_user",  rise_c[b + 6] - rise_c[b + 5], 1 + TS + TE + TH + TX);
    end
`else
    push(32'hFFFF_FE41);              // upper bits ignored -> RS=0? no: bit8=0
    @(negedge clk);
    check("first_data", int'(lcd_data), 8'h41);
    check("first_rs", int'(lcd_rs), 0);
    wait_idle(100, f);
    repeat (2) @(negedge clk);
    check("first_fall", f - x, 1 + 1 + TS + TE + TH + TX);
    if (rise_c.size() > b) check("first_rise", rise_c[b] - x, 1 + 1 + TS);
`endif

    // Single commands: data, clear, function set, home, data 0x03.
    single(32'h0000_0141, 1 + TS + TE + TH + TX);
    single(32'h0000_0001, 1 + TS + TE + TH + TL);
    single(32'h0000_0038, 1 + TS + TE + TH + TX);
    single(32'h0000_0002, 1 + TS + TE + TH + TL);
    single(32'h0000_0103, 1 + TS + TE + TH + TX);

    // Burst of 6 consecutive pushes: 5 accepted, 1 dropped.
    b  = rise_c.size();
    o0 = ovf_n;
    for (int i = 0; i < 6; i++) push(32'h0000_0130 + i);
    wait_idle(300, f);
    repeat (2) @(negedge clk);
    check("burst_ovf", ovf_n - o0, 1);
    check("burst_npulse", rise_c.size() - b, 5);
    if (rise_c.size() - b >= 5) begin
      for (int i = 0; i < 5; i++) check("burst_cmd", rise_d[b + i], 'h130 + i);
      check("burst_gap", rise_c[b + 1] - rise_c[b], 1 + TS + TE + TH + TX);
    end

    // Reset during PULSE with commands queued.
    push(32'h0000_0141);
    push(32'h0000_0142);
    push(32'h0000_0143);
    f = -1;
    for (int i = 0; i < 50; i++) begin
      if (lcd_en) begin f = i; break; end
      @(negedge clk);
    end
    if (f < 0) begin
      checks++;
      $display("FAIL pulse_wait: en never rose, required 1");
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rstp_en", int'(lcd_en), 0);
    check("rstp_cnt", int'(fifo_cnt), 0);
    check("rstp_on", int'(lcd_on), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_on", int'(lcd_on), 1);

    wait_idle(400, f);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Hardware sequencer for the HD44780-style character LCD behind the LCD MMIO register.
- The LSU's LCD write strobe (o_lcd_vld) and the store data push commands into a small FIFO.
- lcd_ctrl pops each command and generates the LCD bus timing: setup, EN pulse, hold and execution delay. Firmware never bit-bangs EN.
- An optional power-on init sequence brings the panel up without firmware help.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- T_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises.
- T_EN_CYC, 12, cycles EN is held high.
- T_HOLD_CYC, 2, cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2000, post-command wait for normal commands and data (40 us at 50 MHz).
- T_LONG_CYC, 82000, post-command wait for clear/home (1.64 ms at 50 MHz).
- T_PWRUP_CYC, 750000, wait before the first init command (15 ms at 50 MHz); used only with LCD_INIT_EN.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_cmd_vld  in  1  push strobe, driven from the LSU o_lcd_vld
- i_cmd_data  in  32  store data: [7:0] byte, [8] RS (1 = data, 0 = instruction), [31:9] ignored
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW, constant 0 (write-only)
- o_lcd_en  out  1  LCD EN
- o_lcd_on  out  1  LCD power enable
- o_busy  out  1  1 while the FIFO is non-empty, the FSM is not IDLE, or init is pending
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_ovf  out  1  one-cycle pulse when a push is dropped

Behaviour:
- Reset values:
  - o_lcd_data = 0, o_lcd_rs = 0, o_lcd_rw = 0, o_lcd_en = 0, o_lcd_on = 0, o_ovf = 0.
  - FIFO empty, FSM in IDLE (or PWRUP with LCD_INIT_EN).
  - Reset mid-command aborts immediately: EN drops to 0 the cycle after reset is sampled and queued commands are lost.
- o_lcd_on is registered; it goes to 1 on the first clock after i_rst_n is released.
- Push:
  - Accepted when i_cmd_vld = 1 and the registered count < FIFO_DEPTH.
  - When count == FIFO_DEPTH, the push is dropped and o_ovf pulses 1 on the next cycle. A pop in the same cycle does not rescue it.
  - Simultaneous push and pop with count < FIFO_DEPTH leaves count unchanged.
- FSM states: PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT.
  - One down-counter (width wide enough for max(T_LONG_CYC, T_PWRUP_CYC)) is loaded on each state entry.
  - IDLE: FIFO non-empty -> pop at cycle t. o_lcd_data/o_lcd_rs are registered from the popped entry and are valid at t+1. Enter SETUP.
  - SETUP: EN = 0 for T_SETUP_CYC cycles -> PULSE.
  - PULSE: EN = 1 for exactly T_EN_CYC cycles -> HOLD.
  - HOLD: EN = 0, data/RS unchanged for T_HOLD_CYC cycles -> WAIT.
  - WAIT: load T_LONG_CYC if RS = 0 and data is 0x01, 0x02 or 0x03; otherwise T_EXEC_CYC. On expiry -> IDLE.
  - A back-to-back queued command is popped in the first IDLE cycle (one IDLE cycle between commands).
- o_lcd_data/o_lcd_rs keep the last command's value while idle.
- Total cycles per command, pop to return to IDLE: 1 + T_SETUP_CYC + T_EN_CYC + T_HOLD_CYC + wait.
- Pushes during any state are accepted; the FIFO absorbs them.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - Reset enters PWRUP and waits T_PWRUP_CYC.
  - The FSM then issues internal instruction commands (RS = 0) from a fixed ROM through the normal SETUP/PULSE/HOLD/WAIT path: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. The 0x01 uses T_LONG_CYC.
  - The FIFO accepts pushes during init but is not popped until the ROM is exhausted.
  - o_busy = 1 throughout init.
- Undefined: no PWRUP state or ROM; reset enters IDLE directly.

Decomposition:
- Package lcd_pkg holds:
  - state enum lcd_state_e;
  - command struct lcd_cmd_t {rs, data[7:0]};
  - default timing localparams;
  - init ROM constant array and its length;
  - is_long_cmd() function.
- One sub-module: lcd_cmd_fifo, a synchronous FIFO of lcd_cmd_t with count, full and empty; no read latency (first-word-fall-through).

Test Plan (bench overrides timing params to T_SETUP_CYC = 2, T_EN_CYC = 3, T_HOLD_CYC = 1, T_EXEC_CYC = 5, T_LONG_CYC = 20, T_PWRUP_CYC = 10, FIFO_DEPTH = 4):
- Single data push 0x141 -> RS = 1, DATA = 0x41 at t+1; EN high exactly cycles t+3..t+5; IDLE at t+12; o_busy falls the same cycle.
- Instruction push 0x001 -> WAIT lasts 20 cycles; 0x038 -> WAIT lasts 5 cycles.
- 6 pushes on consecutive cycles while busy -> first is popped and 4 queued; push 6 drops; o_ovf pulses once; 5 EN pulses are seen in order.
- Reset asserted during PULSE -> next cycle EN = 0, o_fifo_cnt = 0, o_lcd_on = 0; after release, o_lcd_on = 1 one cycle later.
- With LCD_INIT_EN: after reset, 10 idle cycles, then 6 EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. A user push of 0x141 during init is emitted only after 0x06's WAIT.
- Without LCD_INIT_EN: a push 0x141 in the first cycle after reset is popped immediately (DATA = 0x41 one cycle later).
